tetris_game_ctrl: RTL and testbench
===================================

TETRIS_GAME_CTRL -- requirements
Module: tetris_game_ctrl

Interface
REQ-001 Parameter GAME_SPEED, default 60: number of tick pulses per gravity step; legal range 1..255.
REQ-002 Parameter LFSR_SEED, default 7'h5A: reset value of the piece-select LFSR; SHALL be nonzero.
REQ-003 clk  in  1  single system clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 tick  in  1  one-cycle game-tick pulse from RateDivider.
REQ-006 run  in  1  1 = play, 0 = pause.
REQ-007 move_left, move_right, rotate  in  1 each  one-cycle player request pulses.
REQ-008 rotate_direction  in  1  1 = CW, 0 = CCW; sampled in the same cycle as rotate.
REQ-009 cmd_valid  out  1  command to the board datapath is valid.
REQ-010 cmd_op  out  3  command opcode (see REQ-031).
REQ-011 cmd_row  out  5  row index for CLEAR_ROW; 0 otherwise.
REQ-012 cmd_piece  out  3  piece type for SPAWN (0..6); 0 otherwise.
REQ-013 cmd_ready  in  1  datapath accepts the command.
REQ-014 rsp_valid, rsp_ok  in  1 each  command completion pulse and its legality result.
REQ-015 row_full  in  20  one bit per full board row; row 19 is the bottom row.
REQ-016 lines_cleared  out  16  total rows cleared, saturating.
REQ-017 game_over  out  1  high while in state OVER.

Function
REQ-018 FSM states: IDLE, SPAWN, PLAY, WAIT_RSP, LOCK, CLEAR, OVER.
REQ-019 IDLE -> SPAWN on the first cycle with run=1.
REQ-020 Only one command SHALL be outstanding; cmd_valid, cmd_op, cmd_row and cmd_piece SHALL hold stable until the cycle with cmd_ready=1, after which cmd_valid drops the next cycle.
REQ-021 After acceptance, the FSM waits for rsp_valid; rsp_valid in the acceptance cycle itself SHALL be ignored.
REQ-022 SPAWN: issue SPAWN with cmd_piece = LFSR value mod 7; rsp_ok=1 -> PLAY; rsp_ok=0 -> OVER.
REQ-023 The gravity counter SHALL count tick pulses only while run=1 and the state is PLAY or WAIT_RSP; at GAME_SPEED-1 it wraps to 0 and sets gravity_due.
REQ-024 PLAY priority: gravity_due (DOWN) > rotate (ROT_CW/ROT_CCW) > left > right; the chosen request is cleared when issued.
REQ-025 Player pulses SHALL be latched into pending flags, at most one per kind; left and right pending together SHALL both be discarded.
REQ-026 A DOWN response with rsp_ok=0 -> LOCK; any other response -> PLAY.
REQ-027 LOCK: issue LOCK; after its response -> CLEAR.
REQ-028 CLEAR: while row_full != 0, issue CLEAR_ROW for the highest-index set bit and increment lines_cleared after each response (saturating at 16'hFFFF); when row_full == 0 -> SPAWN.
REQ-029 run=0: no new command SHALL be issued, the outstanding command completes, and the counter and pending flags freeze.
REQ-030 OVER SHALL be terminal until reset; player inputs are ignored.
REQ-031 Opcodes: SPAWN=0, LEFT=1, RIGHT=2, ROT_CW=3, ROT_CCW=4, DOWN=5, LOCK=6, CLEAR_ROW=7.
REQ-032 The LFSR is 7-bit maximal (x^7+x^6+1) and advances every cycle.

Reset
REQ-033 Reset SHALL force state IDLE, cmd_valid=0, cmd_op/cmd_row/cmd_piece=0, lines_cleared=0, game_over=0, gravity counter=0, pending flags=0, LFSR=LFSR_SEED.
REQ-034 Reset mid-handshake SHALL abandon the outstanding command; a late rsp_valid in IDLE SHALL be ignored.

Structure
REQ-035 Package tetris_pkg SHALL hold the state enum, the opcode enum, and the constants ROWS=20, COLS=10, NUM_PIECES=7.
REQ-036 Sub-module tetris_piece_lfsr SHALL implement REQ-032.

Verification
REQ-037 Reset, run=1, SPAWN rsp_ok=1 -> cmd_op=0 issued once, then the state is PLAY.
REQ-038 GAME_SPEED=3, ticks on consecutive cycles -> DOWN issued after the 3rd tick; move_left and rotate in the same cycle -> ROT issued before LEFT.
REQ-039 DOWN rsp_ok=0, row_full=20'h80001 -> LOCK, then CLEAR_ROW row 19, then row 0; lines_cleared=2; then SPAWN.
REQ-040 SPAWN rsp_ok=0 -> game_over=1 held for 100 cycles regardless of inputs.
REQ-041 run=0 while cmd_valid=1 -> the command completes, no new cmd_valid for 50 cycles, and ticks are not counted.
REQ-042 reset asserted while waiting on rsp_valid -> all outputs at reset values; a later rsp_valid is ignored.

Source files
------------

// File: rtl/tetris_pkg.sv
// Shared types and constants for the Tetris game controller: FSM states,
// datapath opcodes, board geometry and small decode helpers.
package tetris_pkg;

  localparam int ROWS       = 20;
  localparam int COLS       = 10;
  localparam int NUM_PIECES = 7;
  localparam int ROW_W      = 5;
  localparam int PIECE_W    = 3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SPAWN    = 3'd1,
    ST_PLAY     = 3'd2,
    ST_WAIT_RSP = 3'd3,
    ST_LOCK     = 3'd4,
    ST_CLEAR    = 3'd5,
    ST_OVER     = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    OP_SPAWN     = 3'd0,
    OP_LEFT      = 3'd1,
    OP_RIGHT     = 3'd2,
    OP_ROT_CW    = 3'd3,
    OP_ROT_CCW   = 3'd4,
    OP_DOWN      = 3'd5,
    OP_LOCK      = 3'd6,
    OP_CLEAR_ROW = 3'd7
  } opcode_e;

  // Highest-index full row; row 19 is the bottom, so clearing walks bottom-up.
  function automatic logic [ROW_W-1:0] top_full_row(input logic [ROWS-1:0] full);
    top_full_row = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (full[i]) top_full_row = ROW_W'(i);
    end
  endfunction

  function automatic logic [PIECE_W-1:0] piece_of(input logic [6:0] rnd);
    piece_of = PIECE_W'(rnd % 7'(NUM_PIECES));
  endfunction

endpackage

// File: rtl/tetris_game_ctrl_if.sv
// Command/response channel between the game controller and the board datapath.
interface tetris_game_ctrl_if;
  import tetris_pkg::*;

  logic               cmd_valid;
  logic [2:0]         cmd_op;
  logic [ROW_W-1:0]   cmd_row;
  logic [PIECE_W-1:0] cmd_piece;
  logic               cmd_ready;
  logic               rsp_valid;
  logic               rsp_ok;

  modport master (
    output cmd_valid, cmd_op, cmd_row, cmd_piece,
    input  cmd_ready, rsp_valid, rsp_ok
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_row, cmd_piece,
    output cmd_ready, rsp_valid, rsp_ok
  );

endinterface

// File: rtl/tetris_piece_lfsr.sv
// Free-running 7-bit maximal-length LFSR (x^7 + x^6 + 1) used to pick pieces.
module tetris_piece_lfsr #(
  parameter logic [6:0] SEED = 7'h5A
) (
  input  logic       clk,
  input  logic       reset,
  output logic [6:0] lfsr
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the clock edge.
  always_ff @(posedge clk) begin
    if (reset) lfsr <= SEED;
    else       lfsr <= {lfsr[5:0], lfsr[6] ^ lfsr[5]};
  end

endmodule

// File: rtl/tetris_game_ctrl.sv
// Tetris game controller: sequences spawn/move/drop/lock/clear commands to the
// board datapath with one command outstanding at a time.
module tetris_game_ctrl
  import tetris_pkg::*;
#(
  parameter int unsigned GAME_SPEED = 60,
  parameter logic [6:0]  LFSR_SEED  = 7'h5A
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               run,
  input  logic               move_left,
  input  logic               move_right,
  input  logic               rotate,
  input  logic               rotate_direction,
  tetris_game_ctrl_if.master dp,
  input  logic [ROWS-1:0]    row_full,
  output logic [15:0]        lines_cleared,
  output logic               game_over
);

  localparam logic [7:0] GRAV_MAX = 8'(GAME_SPEED - 1);

  state_e             state_q, state_d;
  logic               cmd_valid_q, cmd_valid_d;
  opcode_e            cmd_op_q, cmd_op_d;
  logic [ROW_W-1:0]   cmd_row_q, cmd_row_d;
  logic [PIECE_W-1:0] cmd_piece_q, cmd_piece_d;
  opcode_e            last_op_q, last_op_d;
  logic [7:0]         grav_cnt_q, grav_cnt_d;
  logic               grav_due_q, grav_due_d;
  logic               pend_left_q, pend_left_d;
  logic               pend_right_q, pend_right_d;
  logic               pend_rot_q, pend_rot_d;
  logic               rot_cw_q, rot_cw_d;
  logic [15:0]        lines_q, lines_d;

  logic               issue;
  opcode_e            issue_op;
  logic [ROW_W-1:0]   issue_row;
  logic [PIECE_W-1:0] issue_piece;
  logic               play_phase;
  logic               grab_inputs;
  logic [6:0]         lfsr;

  tetris_piece_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .lfsr  (lfsr)
  );

  assign play_phase  = (state_q == ST_PLAY) || (state_q == ST_WAIT_RSP);
  assign grab_inputs = run && (state_q != ST_IDLE) && (state_q != ST_OVER);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d      = state_q;
    cmd_valid_d  = cmd_valid_q;
    cmd_op_d     = cmd_op_q;
    cmd_row_d    = cmd_row_q;
    cmd_piece_d  = cmd_piece_q;
    last_op_d    = last_op_q;
    grav_cnt_d   = grav_cnt_q;
    grav_due_d   = grav_due_q;
    pend_left_d  = pend_left_q;
    pend_right_d = pend_right_q;
    pend_rot_d   = pend_rot_q;
    rot_cw_d     = rot_cw_q;
    lines_d      = lines_q;
    issue        = 1'b0;
    issue_op     = OP_SPAWN;
    issue_row    = '0;
    issue_piece  = '0;

    if (cmd_valid_q) begin
      // Command fields hold until accepted; rsp_valid in this cycle belongs to nobody.
      if (dp.cmd_ready) begin
        cmd_valid_d = 1'b0;
        cmd_op_d    = OP_SPAWN;
        cmd_row_d   = '0;
        cmd_piece_d = '0;
        last_op_d   = cmd_op_q;
        state_d     = ST_WAIT_RSP;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (run) state_d = ST_SPAWN;
        end
        ST_SPAWN: begin
          if (run) begin
            issue       = 1'b1;
            issue_op    = OP_SPAWN;
            issue_piece = piece_of(lfsr);
          end
        end
        ST_PLAY: begin
          if (run) begin
            if (grav_due_q) begin
              issue      = 1'b1;
              issue_op   = OP_DOWN;
              grav_due_d = 1'b0;
            end else if (pend_rot_q) begin
              issue      = 1'b1;
              issue_op   = rot_cw_q ? OP_ROT_CW : OP_ROT_CCW;
              pend_rot_d = 1'b0;
            end else if (pend_left_q) begin
              issue       = 1'b1;
              issue_op    = OP_LEFT;
              pend_left_d = 1'b0;
            end else if (pend_right_q) begin
              issue        = 1'b1;
              issue_op     = OP_RIGHT;
              pend_right_d = 1'b0;
            end
          end
        end
        ST_WAIT_RSP: begin
          if (dp.rsp_valid) begin
            case (last_op_q)
              OP_SPAWN: state_d = dp.rsp_ok ? ST_PLAY : ST_OVER;
              OP_DOWN:  state_d = dp.rsp_ok ? ST_PLAY : ST_LOCK;
              OP_LOCK:  state_d = ST_CLEAR;
              OP_CLEAR_ROW: begin
                state_d = ST_CLEAR;
                if (lines_q != 16'hFFFF) lines_d = lines_q + 16'd1;
              end
              default:  state_d = ST_PLAY;
            endcase
          end
        end
        ST_LOCK: begin
          if (run) begin
            issue    = 1'b1;
            issue_op = OP_LOCK;
          end
        end
        ST_CLEAR: begin
          if (row_full == '0) begin
            state_d = ST_SPAWN;
          end else if (run) begin
            issue     = 1'b1;
            issue_op  = OP_CLEAR_ROW;
            issue_row = top_full_row(row_full);
          end
        end
        ST_OVER: begin
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (issue) begin
      cmd_valid_d = 1'b1;
      cmd_op_d    = issue_op;
      cmd_row_d   = issue_row;
      cmd_piece_d = issue_piece;
    end

    // A wrap in the same cycle as a DOWN issue re-arms gravity rather than losing it.
    if (run && tick && play_phase) begin
      if (grav_cnt_q >= GRAV_MAX) begin
        grav_cnt_d = '0;
        grav_due_d = 1'b1;
      end else begin
        grav_cnt_d = grav_cnt_q + 8'd1;
      end
    end

    if (grab_inputs) begin
      if (move_left)  pend_left_d  = 1'b1;
      if (move_right) pend_right_d = 1'b1;
      if (rotate) begin
        pend_rot_d = 1'b1;
        rot_cw_d   = rotate_direction;
      end
      // Contradictory horizontal requests cancel each other.
      if (pend_left_d && pend_right_d) begin
        pend_left_d  = 1'b0;
        pend_right_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cmd_valid_q  <= 1'b0;
      cmd_op_q     <= OP_SPAWN;
      cmd_row_q    <= '0;
      cmd_piece_q  <= '0;
      last_op_q    <= OP_SPAWN;
      grav_cnt_q   <= '0;
      grav_due_q   <= 1'b0;
      pend_left_q  <= 1'b0;
      pend_right_q <= 1'b0;
      pend_rot_q   <= 1'b0;
      rot_cw_q     <= 1'b0;
      lines_q      <= '0;
    end else begin
      state_q      <= state_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_op_q     <= cmd_op_d;
      cmd_row_q    <= cmd_row_d;
      cmd_piece_q  <= cmd_piece_d;
      last_op_q    <= last_op_d;
      grav_cnt_q   <= grav_cnt_d;
      grav_due_q   <= grav_due_d;
      pend_left_q  <= pend_left_d;
      pend_right_q <= pend_right_d;
      pend_rot_q   <= pend_rot_d;
      rot_cw_q     <= rot_cw_d;
      lines_q      <= lines_d;
    end
  end

  assign dp.cmd_valid  = cmd_valid_q;
  assign dp.cmd_op     = cmd_op_q;
  assign dp.cmd_row    = cmd_row_q;
  assign dp.cmd_piece  = cmd_piece_q;
  assign lines_cleared = lines_q;
  assign game_over     = (state_q == ST_OVER);

endmodule

// File: tb/tb_tetris_game_ctrl.sv
// Directed bench for tetris_game_ctrl: plays the datapath side of the command
// channel and checks every command, state outcome and counter by hand-worked values.
module tb_tetris_game_ctrl;
  import tetris_pkg::*;

  localparam logic [6:0] SEED = 7'h5A;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b0;
  logic        run = 1'b0;
  logic        move_left = 1'b0;
  logic        move_right = 1'b0;
  logic        rotate = 1'b0;
  logic        rotate_direction = 1'b0;
  logic [19:0] row_full = '0;
  logic [15:0] lines_cleared;
  logic        game_over;

  int n_total = 0;
  int n_bad   = 0;

  tetris_game_ctrl_if dp_bus ();

  tetris_game_ctrl #(.GAME_SPEED(3), .LFSR_SEED(SEED)) dut (
    .clk              (clk),
    .reset            (reset),
    .tick             (tick),
    .run              (run),
    .move_left        (move_left),
    .move_right       (move_right),
    .rotate           (rotate),
    .rotate_direction (rotate_direction),
    .dp               (dp_bus.master),
    .row_full         (row_full),
    .lines_cleared    (lines_cleared),
    .game_over        (game_over)
  );

  always #5 clk = ~clk;

  // Reference x^7+x^6+1 sequence; lfsr_hist holds the value seen at the last edge.
  logic [6:0] lfsr_m, lfsr_hist;
  always @(posedge clk) begin
    lfsr_hist <= lfsr_m;
    if (reset) lfsr_m <= SEED;
    else       lfsr_m <= {lfsr_m[5:0], lfsr_m[6] ^ lfsr_m[5]};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic count_valid(input int cycles, output int hits);
    hits = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (dp_bus.cmd_valid) hits++;
    end
  endtask

  task automatic wait_cmd(input string tag, input opcode_e op, input logic [4:0] row);
    int n = 0;
    logic [2:0] exp_piece;
    while (!dp_bus.cmd_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    exp_piece = (op == OP_SPAWN) ? 3'(lfsr_hist % 7'd7) : 3'd0;
    check({tag, "_valid"}, 32'(dp_bus.cmd_valid), 32'd1);
    check({tag, "_op"},    32'(dp_bus.cmd_op),    32'(op));
    check({tag, "_row"},   32'(dp_bus.cmd_row),   32'(row));
    check({tag, "_piece"}, 32'(dp_bus.cmd_piece), 32'(exp_piece));
    @(negedge clk);
    check({tag, "_hold"}, {28'd0, dp_bus.cmd_valid, dp_bus.cmd_op}, {28'd0, 1'b1, op});
  endtask

  // Acceptance cycle carries a bogus response that must be ignored.
  task automatic accept_cmd(input string tag, input logic ok);
    dp_bus.cmd_ready = 1'b1;
    dp_bus.rsp_valid = 1'b1;
    dp_bus.rsp_ok    = ~ok;
    @(negedge clk);
    dp_bus.cmd_ready = 1'b0;
    dp_bus.rsp_valid = 1'b0;
    dp_bus.rsp_ok    = 1'b0;
    check({tag, "_drop"}, 32'(dp_bus.cmd_valid), 32'd0);
  endtask

  task automatic respond(input logic ok);
    @(negedge clk);
    dp_bus.rsp_valid = 1'b1;
    dp_bus.rsp_ok    = ok;
    @(negedge clk);
    dp_bus.rsp_valid = 1'b0;
    dp_bus.rsp_ok    = 1'b0;
  endtask

  task automatic do_cmd(input string tag, input opcode_e op, input logic [4:0] row, input logic ok);
    wait_cmd(tag, op, row);
    accept_cmd(tag, ok);
    respond(ok);
  endtask

  task automatic pulse(input logic l, input logic r, input logic rot, input logic dir);
    move_left = l; move_right = r; rotate = rot; rotate_direction = dir;
    @(negedge clk);
    move_left = 1'b0; move_right = 1'b0; rotate = 1'b0; rotate_direction = 1'b0;
  endtask

  task automatic ticks(input int n);
    tick = 1'b1;
    repeat (n) @(negedge clk);
    tick = 1'b0;
  endtask

  initial begin
    int hits;
    dp_bus.cmd_ready = 1'b0;
    dp_bus.rsp_valid = 1'b0;
    dp_bus.rsp_ok    = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_valid", 32'(dp_bus.cmd_valid), 32'd0);
    check("rst_fields", {21'd0, dp_bus.cmd_op, dp_bus.cmd_row, dp_bus.cmd_piece}, 32'd0);
    check("rst_lines", 32'(lines_cleared), 32'd0);
    check("rst_over", 32'(game_over), 32'd0);
    check("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    reset = 1'b0;
    count_valid(5, hits);
    check("idle_no_cmd", hits, 0);

    // First spawn, issued exactly once
    run = 1'b1;
    do_cmd("spawn1", OP_SPAWN, 5'd0, 1'b1);
    count_valid(10, hits);
    check("spawn_once", hits, 0);
    check("spawn_play", 32'(dut.state_q), 32'(ST_PLAY));

    // Gravity: DOWN only after the third tick
    tick = 1'b1;
    repeat (2) @(negedge clk);
    check("down_early", 32'(dp_bus.cmd_valid), 32'd0);
    @(negedge clk);
    tick = 1'b0;
    do_cmd("down1", OP_DOWN, 5'd0, 1'b1);

    // Priority: rotate beats left; rotate CCW beats right; left+right cancel
    pulse(1'b1, 1'b0, 1'b1, 1'b1);
    do_cmd("rot_cw", OP_ROT_CW, 5'd0, 1'b1);
    do_cmd("left", OP_LEFT, 5'd0, 1'b0);
    check("left_nok_play", 32'(dut.state_q), 32'(ST_PLAY));
    pulse(1'b0, 1'b1, 1'b1, 1'b0);
    do_cmd("rot_ccw", OP_ROT_CCW, 5'd0, 1'b1);
    do_cmd("right", OP_RIGHT, 5'd0, 1'b1);
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    count_valid(10, hits);
    check("lr_cancel", hits, 0);

    // Blocked DOWN -> LOCK -> clear rows 19 then 0 -> SPAWN
    row_full = 20'h80001;
    ticks(3);
    do_cmd("down_blk", OP_DOWN, 5'd0, 1'b0);
    do_cmd("lock", OP_LOCK, 5'd0, 1'b1);
    do_cmd("clr19", OP_CLEAR_ROW, 5'd19, 1'b1);
    row_full = 20'h00001;
    check("lines_1", 32'(lines_cleared), 32'd1);
    do_cmd("clr0", OP_CLEAR_ROW, 5'd0, 1'b1);
    row_full = 20'h00000;
    check("lines_2", 32'(lines_cleared), 32'd2);
    do_cmd("spawn2", OP_SPAWN, 5'd0, 1'b1);

    // Pause with a command outstanding
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    wait_cmd("left_p", OP_LEFT, 5'd0);
    run = 1'b0;
    tick = 1'b1;
    move_right = 1'b1;
    repeat (5) @(negedge clk);
    tick = 1'b0;
    move_right = 1'b0;
    check("pause_hold", {28'd0, dp_bus.cmd_valid, dp_bus.cmd_op}, {28'd0, 1'b1, OP_LEFT});
    accept_cmd("left_p", 1'b1);
    respond(1'b1);
    check("pause_done", 32'(dut.state_q), 32'(ST_PLAY));
    tick = 1'b1;
    count_valid(50, hits);
    tick = 1'b0;
    check("pause_quiet", hits, 0);
    run = 1'b1;
    count_valid(10, hits);
    check("resume_quiet", hits, 0);
    ticks(2);
    count_valid(3, hits);
    check("resume_cnt0", hits, 0);
    ticks(1);

    // Reset while waiting for the DOWN response
    wait_cmd("down_r", OP_DOWN, 5'd0);
    accept_cmd("down_r", 1'b1);
    reset = 1'b1;
    run = 1'b0;
    repeat (2) @(negedge clk);
    check("mid_rst_valid", 32'(dp_bus.cmd_valid), 32'd0);
    check("mid_rst_fields", {21'd0, dp_bus.cmd_op, dp_bus.cmd_row, dp_bus.cmd_piece}, 32'd0);
    check("mid_rst_lines", 32'(lines_cleared), 32'd0);
    check("mid_rst_over", 32'(game_over), 32'd0);
    check("mid_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    reset = 1'b0;
    dp_bus.rsp_valid = 1'b1;
    dp_bus.rsp_ok    = 1'b1;
    @(negedge clk);
    dp_bus.rsp_valid = 1'b0;
    dp_bus.rsp_ok    = 1'b0;
    count_valid(4, hits);
    check("late_rsp_valid", hits, 0);
    check("late_rsp_state", 32'(dut.state_q), 32'(ST_IDLE));

    // Failed spawn -> terminal game over
    run = 1'b1;
    do_cmd("spawn_fail", OP_SPAWN, 5'd0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      move_left        = 1'($urandom);
      move_right       = 1'($urandom);
      rotate           = 1'($urandom);
      rotate_direction = 1'($urandom);
      tick             = 1'($urandom);
      run              = 1'($urandom);
      dp_bus.cmd_ready = 1'($urandom);
      dp_bus.rsp_valid = 1'($urandom);
      dp_bus.rsp_ok    = 1'($urandom);
      row_full         = 20'($urandom);
      @(negedge clk);
      check("over_hold", 32'(game_over), 32'd1);
      check("over_no_cmd", 32'(dp_bus.cmd_valid), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
